muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle HI/LO multiply/divide unit that serves the EX stage.
//  EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with a Start pulse.
//  The unit computes the result iteratively, then writes HI/LO and pulses Done.
//  EX reads HI/LO (MFHI/MFLO) from the outputs and stalls while Busy=1.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  Clock  in   1      rising-edge clock
//  Reset  in   1      asynchronous, active-high; clears all state
//  Start  in   1      request valid; sampled on Clock edge
//  Func   in   6      op: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
//  A      in   WIDTH  rs operand (multiplicand/dividend/MT source)
//  B      in   WIDTH  rt operand (multiplier/divisor)
//  Flush  in   1      cancel in-flight op (pipeline flush)
//  Busy   out  1      op in progress; EX must not Start or read HI/LO
//  Done   out  1      one-cycle pulse; HI/LO updated this cycle
//  HI     out  WIDTH  HI register
//  LO     out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; HI=0, LO=0, Busy=0, Done=0; internal regs cleared, also mid-op.
//  FSM IDLE -> CALC -> FIX -> IDLE. Busy=1 in CALC and FIX. Done is registered.
//  IDLE, Start, Func MULT/MULTU/DIV/DIVU: capture A, B, signedness and op.
//    Signed ops capture magnitudes plus sign bits. Count=0; go to CALC.
//  IDLE, Start, MTHI/MTLO: write HI or LO = A on that edge. Single cycle.
//    Busy stays 0; Done=1 next cycle.
//  IDLE, Start, any other Func: ignored; no state change.
//  CALC: one iteration per edge, WIDTH edges.
//    Multiply: radix-2 shift-add on unsigned magnitudes into a 2*WIDTH-bit product.
//    Divide: restoring shift-subtract on unsigned magnitudes.
//  FIX: apply signs and write HI/LO. State -> IDLE; Done=1 for the following cycle.
//    Multiply: product negated if sign(A)^sign(B) (signed ops only).
//      {HI,LO} = product.
//    Divide: LO=quotient, HI=remainder.
//      Signed quotient sign = sign(A)^sign(B); remainder sign = sign(A).
//  Latency: Start captured at edge 0. HI/LO new and Done=1 after edge WIDTH+1 (33).
//    Busy=1 from after edge 0 to edge 33 (33 cycles).
//  Start is accepted in the Done cycle, because the state is IDLE by then.
//  Start while Busy: ignored. HI/LO hold old values until FIX.
//  Divide by zero (B=0, any divide): LO=all ones, HI=A. Same latency; no trap.
//  Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//  Flush in any state: next state IDLE, Busy=0, Done=0. HI/LO unchanged.
//    Flush has priority over Start and over the FIX write.
//  HI/LO change only on FIX, MTHI/MTLO, or Reset.
// TESTING
//  MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE LO=0x00000001, Done 1 cycle
//  MULT A=-3 B=7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB. Busy high exactly 33 cycles.
//  DIV A=-7 B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF. DIVU A=100 B=0 -> LO=0xFFFFFFFF HI=100.
//  MTHI A=0x1234 then MTLO A=0x5678 back-to-back -> HI=0x1234 LO=0x5678. Busy never set.
//  MULT in flight; Start DIV at cycle 5 -> ignored. Flush at cycle 10 -> Busy=0, HI/LO old values, no Done.
//  Reset asserted mid-DIVU -> Busy/Done/HI/LO=0 immediately (async). Next MULTU 2*3 -> LO=6 HI=0.

Source files
------------

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage (master) and muldiv_unit (slave).
`default_nettype none

interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, func, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, func, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit: iterative HI/LO multiply/divide unit (shift-add / restoring)
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic [1:0]         state_q,  state_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   opnd_q,   opnd_d;
  logic               sign_a_q, sign_a_d;
  logic               neg_q,    neg_d;
  logic               is_div_q, is_div_d;
  logic               bzero_q,  bzero_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic               done_q,   done_d;

  logic             w_is_mul, w_is_div, w_signed, w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_sum, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo, w_rem;

  assign w_is_mul = (bus.func == F_MULT) || (bus.func == F_MULTU);
  assign w_is_div = (bus.func == F_DIV)  || (bus.func == F_DIVU);
  assign w_signed = (bus.func == F_MULT) || (bus.func == F_DIV);
  assign w_sa     = w_signed & bus.a[WIDTH-1];
  assign w_sb     = w_signed & bus.b[WIDTH-1];
  assign w_mag_a  = w_sa ? -bus.a : bus.a;
  assign w_mag_b  = w_sb ? -bus.b : bus.b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
  assign w_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
  // Divide: acc = {partial remainder, dividend/quotient bits}, shifting left.
  assign w_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, opnd_q};

  assign w_prod = neg_q ? -acc_q : acc_q;
  assign w_quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign w_rem  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      sign_a_q <= sign_a_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start && (w_is_mul || w_is_div)) state_d = S_CALC;
      S_CALC:  if (count_q == C_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_comb begin
    count_d  = count_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    neg_d    = neg_q;
    is_div_d = is_div_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (w_is_mul || w_is_div)) begin
          count_d  = '0;
          acc_d    = {{WIDTH{1'b0}}, (w_is_mul ? w_mag_b : w_mag_a)};
          opnd_d   = w_is_mul ? w_mag_a : w_mag_b;
          sign_a_d = w_sa;
          neg_d    = w_sa ^ w_sb;
          is_div_d = w_is_div;
          bzero_d  = (bus.b == '0);
        end else if (bus.start && (bus.func == F_MTHI)) begin
          hi_d   = bus.a;
          done_d = 1'b1;
        end else if (bus.start && (bus.func == F_MTLO)) begin
          lo_d   = bus.a;
          done_d = 1'b1;
        end
      end
      S_CALC: begin
        count_d = count_q + CW'(1);
        if (is_div_q) begin
          if (!w_diff[WIDTH]) acc_d = {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                acc_d = {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {w_sum, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = w_prod;
        end else if (bzero_q) begin
          // Divide by zero leaves |A| in the remainder; re-signing it restores A.
          lo_d = {WIDTH{1'b1}};
          hi_d = w_rem;
        end else begin
          lo_d = w_quo;
          hi_d = w_rem;
        end
      end
      default: ;
    endcase
    if (bus.flush) begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
    end
  end

  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = done_q;
    bus.hi   = hi_q;
    bus.lo   = lo_q;
  end
endmodule

`default_nettype wire
